// File: rtl/cmd_frame_asm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cmd_frame_asm
//  Purpose  : Assembles 45-byte command frames (header, 43 payload bytes,
//             checksum) received byte-by-byte from the MCU serial receiver.
//             It then presents the decoded DDS/burst command fields with a
//             one-cycle WR strobe.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK           in   1   system clock (48 MHz)
//    RESET         in   1   synchronous active-high reset
//    RX_DATA       in   8   received byte
//    RX_VALID      in   1   RX_DATA qualifier, one pulse per byte
//    FREQ          out 48   DDS start frequency
//    FREQ_STEP     out 48   frequency step
//    FREQ_RATE     out 32   step rate
//    TIME_START    out 64   start time
//    N_impuls      out 16   pulse count
//    TYPE_impulse  out  2   burst type
//    Interval_Ti   out 32   interval Ti
//    Interval_Tp   out 32   interval Tp
//    Tblank1       out 32   blanking interval 1
//    Tblank2       out 32   blanking interval 2
//    WR            out  1   one-cycle strobe: new command on the outputs
//    BUSY          out  1   frame assembly in progress
//    ERR_CNT       out  8   saturating count of rejected / timed-out frames
// ----------------------------------------------------------------------------
//  Build option
//    CMD_CHECKSUM_CHECK_EN  defined   : checksum byte is verified; a bad
//                                       frame is dropped and counted.
//                           undefined : checksum byte is consumed only;
//                                       every complete frame commits.
// ============================================================================
module cmd_frame_asm #(
    parameter int         TIMEOUT_CYC = 4800,
    parameter logic [7:0] HDR_BYTE    = 8'hA5
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic [47:0] FREQ,
    output logic [47:0] FREQ_STEP,
    output logic [31:0] FREQ_RATE,
    output logic [63:0] TIME_START,
    output logic [15:0] N_impuls,
    output logic [1:0]  TYPE_impulse,
    output logic [31:0] Interval_Ti,
    output logic [31:0] Interval_Tp,
    output logic [31:0] Tblank1,
    output logic [31:0] Tblank2,
    output logic        WR,
    output logic        BUSY,
    output logic [7:0]  ERR_CNT
);

    localparam int             C_PAYLOAD_LEN = 43;
    localparam int             C_SHADOW_W    = C_PAYLOAD_LEN * 8;
    localparam logic [5:0]     C_LAST_IDX    = 6'(C_PAYLOAD_LEN - 1);
    localparam int             C_GAP_W       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [C_GAP_W-1:0] C_GAP_LAST = C_GAP_W'(TIMEOUT_CYC - 1);
    localparam logic [C_GAP_W-1:0] C_GAP_ONE  = C_GAP_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [5:0]            r_idx;
    logic [C_GAP_W-1:0]    r_gap;
    // Payload is shifted in MSB-first, so after 43 bytes the first payload
    // byte sits in the top byte and each field is a fixed slice.
    logic [C_SHADOW_W-1:0] r_shadow;
    logic                  w_timeout;
    logic                  w_commit;
    logic                  w_reject;
    logic                  w_sum_ok;
    logic                  w_unused_type_hi;

`ifdef CMD_CHECKSUM_CHECK_EN
    logic [7:0] r_sum;
    assign w_sum_ok = (r_sum == RX_DATA);
`else
    assign w_sum_ok = 1'b1;
`endif

    // Upper six bits of the TYPE byte carry no meaning.
    assign w_unused_type_hi = ^r_shadow[135:130];

    assign BUSY = (r_state != ST_IDLE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and frame decisions
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        w_commit    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (RX_VALID && (RX_DATA == HDR_BYTE)) begin
                    w_state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (RX_VALID) begin
                    if (r_idx == C_LAST_IDX) begin
                        w_state_nxt = ST_CHECK;
                    end
                end else if (r_gap == C_GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            ST_CHECK: begin
                if (RX_VALID) begin
                    w_state_nxt = ST_IDLE;
                    if (w_sum_ok) begin
                        w_commit = 1'b1;
                    end else begin
                        w_reject = 1'b1;
                    end
                end else if (r_gap == C_GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: index, gap timer, shadow, running sum
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_idx    <= 6'd0;
            r_gap    <= '0;
            r_shadow <= '0;
`ifdef CMD_CHECKSUM_CHECK_EN
            r_sum    <= 8'd0;
`endif
        end else if (r_state == ST_IDLE) begin
            r_idx <= 6'd0;
            r_gap <= '0;
`ifdef CMD_CHECKSUM_CHECK_EN
            r_sum <= 8'd0;
`endif
        end else if (RX_VALID) begin
            r_gap <= '0;
            if (r_state == ST_PAYLOAD) begin
                r_shadow <= {r_shadow[C_SHADOW_W-9:0], RX_DATA};
                r_idx    <= r_idx + 6'd1;
`ifdef CMD_CHECKSUM_CHECK_EN
                r_sum    <= r_sum + RX_DATA;
`endif
            end
        end else begin
            r_gap <= w_timeout ? '0 : (r_gap + C_GAP_ONE);
        end
    end

    // ------------------------------------------------------------------
    // Committed command outputs, WR strobe and error counter
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            FREQ         <= '0;
            FREQ_STEP    <= '0;
            FREQ_RATE    <= '0;
            TIME_START   <= '0;
            N_impuls     <= '0;
            TYPE_impulse <= '0;
            Interval_Ti  <= '0;
            Interval_Tp  <= '0;
            Tblank1      <= '0;
            Tblank2      <= '0;
            WR           <= 1'b0;
            ERR_CNT      <= 8'd0;
        end else begin
            WR <= w_commit;
            if (w_commit) begin
                FREQ         <= r_shadow[343:296];
                FREQ_STEP    <= r_shadow[295:248];
                FREQ_RATE    <= r_shadow[247:216];
                TIME_START   <= r_shadow[215:152];
                N_impuls     <= r_shadow[151:136];
                TYPE_impulse <= r_shadow[129:128];
                Interval_Ti  <= r_shadow[127:96];
                Interval_Tp  <= r_shadow[95:64];
                Tblank1      <= r_shadow[63:32];
                Tblank2      <= r_shadow[31:0];
            end
            if ((w_reject || w_timeout) && (ERR_CNT != 8'hFF)) begin
                ERR_CNT <= ERR_CNT + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/cmd_frame_asm.md
CMD_FRAME_ASM -- requirements
Module: cmd_frame_asm

Interface
REQ-001 Parameter: TIMEOUT_CYC, 4800, maximum allowed clocks between consecutive frame bytes (100 us at 48 MHz).
REQ-002 Parameter: HDR_BYTE, 8'hA5, frame start marker.
REQ-003 One clock; reset is synchronous and active-high; ports named CLK and RESET.
REQ-004 CLK  in  1  48 MHz system clock.
REQ-005 RESET  in  1  synchronous active-high reset.
REQ-006 RX_DATA  in  8  byte from MCU serial receiver.
REQ-007 RX_VALID  in  1  RX_DATA qualifier, one-cycle pulse per byte.
REQ-008 FREQ  out  48  assembled DDS start frequency.
REQ-009 FREQ_STEP  out  48  assembled frequency step.
REQ-010 FREQ_RATE  out  32  assembled step rate.
REQ-011 TIME_START  out  64  assembled start time.
REQ-012 N_impuls  out  16  pulse count.
REQ-013 TYPE_impulse  out  2  burst type.
REQ-014 Interval_Ti, Interval_Tp, Tblank1, Tblank2  out  32 each  interval fields.
REQ-015 WR  out  1  one-cycle strobe: a new complete command is on the outputs; drives the command register WR input.
REQ-016 BUSY  out  1  high while a frame is being assembled.
REQ-017 ERR_CNT  out  8  saturating count of rejected frames.

Function
REQ-018 Frame = HDR_BYTE, 43 payload bytes, 1 checksum byte; 45 bytes total.
REQ-019 Payload order, each field MSB first: FREQ(6), FREQ_STEP(6), FREQ_RATE(4), TIME_START(8), N_impuls(2), TYPE(1, bits[1:0] used, [7:2] ignored), Ti(4), Tp(4), Tblank1(4), Tblank2(4).
REQ-020 Checksum = sum of the 43 payload bytes mod 256.
REQ-021 States: IDLE, PAYLOAD, CHECK; a byte acts only in a cycle where RX_VALID=1.
REQ-022 IDLE: byte == HDR_BYTE -> PAYLOAD with byte index 0; any other byte is dropped, no error.
REQ-023 PAYLOAD: byte goes to a shadow register at the current index, running sum updated; after index 42 -> CHECK.
REQ-024 CHECK: byte accepted -> IDLE; if valid, shadow is copied to the outputs and WR=1 in the next cycle; else outputs unchanged and ERR_CNT increments.
REQ-025 Outputs change only on a committed frame and stay stable otherwise, including across rejected frames.
REQ-026 Latency: WR and the new outputs appear exactly 1 clock after the checksum byte's RX_VALID cycle.
REQ-027 Gap timer: reloads on every accepted byte; in PAYLOAD/CHECK, TIMEOUT_CYC clocks without RX_VALID -> IDLE, shadow discarded, ERR_CNT increments.
REQ-028 HDR_BYTE inside PAYLOAD/CHECK is ordinary data; no resynchronisation.
REQ-029 An RX_VALID byte in the WR cycle is handled by IDLE rules, so back-to-back frames are allowed.
REQ-030 ERR_CNT saturates at 255 and clears only on RESET.
REQ-031 BUSY = (state != IDLE).

Reset
REQ-032 RESET forces IDLE and index 0, clears the gap timer and running sum, and sets all field outputs, WR and ERR_CNT to 0.
REQ-033 RESET mid-frame discards the partial frame; no WR and no error count result.

Configuration
REQ-034 Macro CMD_CHECKSUM_CHECK_EN defined: REQ-024 checksum comparison applies.
REQ-035 Macro undefined: the checksum byte is consumed but every frame reaching CHECK commits; ERR_CNT counts timeouts only; summing logic is removed.

Verification
REQ-036 Valid frame, FREQ=48'h001000000000, FREQ_STEP=48'h100000, FREQ_RATE=32'h100, TIME_START=64'h12C0, N_impuls=2, TYPE=1, Ti=Tp=32'h1800, Tblank1=Tblank2=32'h180, correct checksum -> one WR pulse 1 clock after the checksum byte, all fields exact, ERR_CNT=0.
REQ-037 Same frame with checksum+1 -> no WR, outputs keep their previous values, ERR_CNT=1; with the macro undefined -> WR asserted.
REQ-038 20 payload bytes, then a 4800-clock gap -> IDLE, ERR_CNT=1, BUSY=0; a following valid frame commits normally.
REQ-039 Bytes 8'h00, 8'h5A before the header -> ignored, ERR_CNT=0, frame commits.
REQ-040 Two frames back to back, the second header arriving in the WR cycle -> two WR pulses, second field values correct.
REQ-041 RESET at payload byte 30 -> all outputs 0, no WR; 256 bad frames -> ERR_CNT=255.
